drac_burst: RTL and testbench
=============================

DRAC_BURST -- requirements
Module: drac_burst

Interface
REQ-001 SHALL have parameter N_WR, default 42, number of 8-bit read/write registers.
REQ-002 SHALL have parameter N_RD, default 6, number of 8-bit read-only registers; N_WR+N_RD SHALL be in 2..128.
REQ-003 SHALL have parameter AUTO_INC, default 1; 1 means the address increments after each data byte, 0 means the address is held.
REQ-004 SHALL have parameter WRAP, default 1; 1 means the address wraps to 0 past the last address, 0 means it saturates at the last address.
REQ-005 SHALL have a single clock, clk; reset rst is synchronous and active-high.
REQ-006 SHALL have these ports (name, direction, width, meaning), clock and reset first:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cs  in  1  SPI chip select, active-low, already synchronous to clk.
- rx_valid  in  1  one-cycle pulse; received byte is on rx_data.
- rx_data  in  8  received byte.
- tx_req  in  1  one-cycle pulse; SPI core has consumed tx_data.
- tx_data  out  8  byte presented for the next MISO byte.
- regwr  out  N_WR*8  flat register outputs; register i is bits [8i+7:8i].
- regr  in  N_RD*8  flat read-only inputs.
- wr_stb  out  N_WR  one-cycle pulse per register written.
- err_cnt  out  8  saturating count of illegal writes.
- busy  out  1  high whenever state is not IDLE.

Function
REQ-007 Address map: 0..N_WR-1 SHALL be RW registers; N_WR..N_WR+N_RD-1 SHALL be regr slices; higher addresses are out of range.
REQ-008 The first byte of each frame SHALL be the command byte: bit7 = 1 for write, 0 for read; bits6:0 = start address.
REQ-009 The FSM SHALL have states IDLE, CMD, WDATA, RDATA.
REQ-010 IDLE SHALL go to CMD on the first cycle with cs=0.
REQ-011 CMD SHALL, on rx_valid, latch the address and go to WDATA if bit7=1, else RDATA.
REQ-012 Any state SHALL return to IDLE in the cycle after cs=1 is sampled.
REQ-013 If cs=1 and rx_valid occur in the same cycle, the byte SHALL be discarded.
REQ-014 In WDATA, an rx_valid to an in-range RW address SHALL update that register in the next cycle and pulse wr_stb[addr] in that same cycle.
REQ-015 In WDATA, an rx_valid to a read-only or out-of-range address SHALL change no register and SHALL increment err_cnt, saturating at 255.
REQ-016 RDATA entry SHALL load tx_data with the value at the current address and then advance the address.
REQ-017 Each tx_req in RDATA SHALL load tx_data with the value at the current address and then advance the address.
REQ-018 An out-of-range read SHALL return 0x00.
REQ-019 RW registers SHALL be readable, returning their current value.
REQ-020 Address advance SHALL follow AUTO_INC and WRAP; WRAP wraps modulo N_WR+N_RD; a command address at or beyond N_WR+N_RD SHALL not wrap until it reaches 127 and then return to 0.
REQ-021 rx_valid SHALL be ignored in RDATA and IDLE; tx_req SHALL be ignored outside RDATA.
REQ-022 tx_data SHALL be 0x00 in IDLE and CMD.
REQ-023 regr SHALL be sampled at the load cycle with no additional latency.

Reset
REQ-024 On rst=1, state SHALL be IDLE, all regwr 0x00, wr_stb 0, err_cnt 0, tx_data 0x00, address 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame; after rst falls, the next frame SHALL require cs to go high and then low again.

Structure
REQ-026 Package drac_pkg SHALL hold:
- the state enum;
- the command bit positions (CMD_WR_BIT=7, CMD_ADDR_W=7);
- the address-width function max(1, clog2(N_WR+N_RD)).
REQ-027 A single sub-module, drac_regfile, SHALL contain RW storage, write decode, strobes and the read mux; the FSM, address counter and err_cnt SHALL remain in drac_burst.

Verification
REQ-028 Write burst: cmd 0x82, data 0x11,0x22,0x33 -> regwr[2..4] = 0x11,0x22,0x33, each wr_stb pulse one cycle, err_cnt = 0.
REQ-029 Read wrap (N_WR=42, N_RD=6, WRAP=1): regr[5]=0xA5, cmd 0x2F, three tx_req -> tx_data sequence 0xA5, regwr[0], regwr[1].
REQ-030 Illegal writes: cmd 0xAA (address 42), two data bytes -> no regwr change, err_cnt = 2; 300 such bytes -> err_cnt = 255.
REQ-031 AUTO_INC=0: cmd 0x85, data 0x01,0x02 -> regwr[5] = 0x02, wr_stb[5] pulses twice.
REQ-032 Abort: cs rises with rx_valid in the same cycle during WDATA -> byte dropped, state IDLE next cycle; rst mid-RDATA -> tx_data 0x00 and all regwr 0x00.

Source files
------------

// File: rtl/drac_pkg.sv
// Shared types and constants for the drac_burst SPI register bridge.
package drac_pkg;

  // Frame sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMD   = 2'd1,
    ST_WDATA = 2'd2,
    ST_RDATA = 2'd3
  } state_t;

  // Command byte layout: bit7 selects write, bits 6:0 carry the start address.
  localparam int CMD_WR_BIT = 7;
  localparam int CMD_ADDR_W = 7;

  // Bits needed to index every implemented byte, never less than one.
  function automatic int addr_w(input int n_regs);
    int w;
    w = $clog2(n_regs);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/drac_regfile.sv
// Register storage for drac_burst: RW bytes, write decode, write strobes and
// the combined RW / read-only read mux.
module drac_regfile
  import drac_pkg::*;
#(
  parameter int N_WR = 42,
  parameter int N_RD = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [CMD_ADDR_W-1:0] i_wr_addr,
  input  logic [7:0]            i_wr_data,
  input  logic [CMD_ADDR_W-1:0] i_rd_addr,
  input  logic [N_RD*8-1:0]     i_regr,
  output logic [N_WR*8-1:0]     o_regwr,
  output logic [N_WR-1:0]       o_wr_stb,
  output logic [7:0]            o_rd_data,
  output logic                  o_wr_legal
);

  localparam int N_TOT = N_WR + N_RD;
  localparam int AW    = addr_w(N_TOT);

  logic [7:0]      r_regs [N_WR];
  logic [N_WR-1:0] r_wr_stb;
  logic [7:0]      w_bytes [N_TOT];
  logic            w_rd_in_range;

  // Only addresses below N_WR hold writable storage.
  assign o_wr_legal = ({1'b0, i_wr_addr} < 8'(N_WR));

  // Write decode: update the addressed byte and raise its strobe for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_WR; i++) r_regs[i] <= 8'h00;
      r_wr_stb <= '0;
    end else begin
      r_wr_stb <= '0;
      for (int i = 0; i < N_WR; i++) begin
        if (i_wr_en && (i_wr_addr == CMD_ADDR_W'(i))) begin
          r_regs[i]   <= i_wr_data;
          r_wr_stb[i] <= 1'b1;
        end
      end
    end
  end

  // Unified byte view: RW storage first, then the live read-only inputs.
  for (genvar gi = 0; gi < N_WR; gi++) begin : g_rw
    assign w_bytes[gi]           = r_regs[gi];
    assign o_regwr[8*gi +: 8]    = r_regs[gi];
  end

  for (genvar gj = 0; gj < N_RD; gj++) begin : g_ro
    assign w_bytes[N_WR+gj] = i_regr[8*gj +: 8];
  end

  // Anything past the implemented map reads as zero.
  assign w_rd_in_range = ({1'b0, i_rd_addr} < 8'(N_TOT));
  assign o_rd_data     = w_rd_in_range ? w_bytes[i_rd_addr[AW-1:0]] : 8'h00;
  assign o_wr_stb      = r_wr_stb;

endmodule

// File: rtl/drac_burst.sv
// SPI burst register bridge: decodes a command byte, then streams writes into
// the register file or reads out through tx_data, with address auto-advance.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | cs high (or waiting for cs to go high after reset)
// ST_CMD   | frame open, waiting for the command byte
// ST_WDATA | each received byte writes the current address
// ST_RDATA | each tx_req reloads tx_data from the current address
module drac_burst
  import drac_pkg::*;
#(
  parameter int N_WR     = 42,
  parameter int N_RD     = 6,
  parameter int AUTO_INC = 1,
  parameter int WRAP     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  input  logic              tx_req,
  output logic [7:0]        tx_data,
  output logic [N_WR*8-1:0] regwr,
  input  logic [N_RD*8-1:0] regr,
  output logic [N_WR-1:0]   wr_stb,
  output logic [7:0]        err_cnt,
  output logic              busy
);

  localparam int                    N_TOT     = N_WR + N_RD;
  localparam logic [CMD_ADDR_W-1:0] ADDR_TOP  = {CMD_ADDR_W{1'b1}};
  localparam logic [CMD_ADDR_W-1:0] ADDR_ZERO = {CMD_ADDR_W{1'b0}};

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_wait_cs_hi;
  logic [CMD_ADDR_W-1:0] r_addr;
  logic [7:0]            r_tx_data;
  logic [7:0]            r_err_cnt;

  logic                  w_busy;
  logic                  w_cmd_byte;
  logic                  w_wr_byte;
  logic                  w_rd_cmd;
  logic                  w_rd_next;
  logic                  w_load;
  logic [CMD_ADDR_W-1:0] w_cmd_addr;
  logic [CMD_ADDR_W-1:0] w_rd_addr;
  logic [7:0]            w_rd_data;
  logic                  w_wr_legal;

  // In-map addresses wrap (or stick) at the last implemented byte; addresses
  // that start beyond the map run up to the top of the 7-bit space first.
  function automatic logic [CMD_ADDR_W-1:0] next_addr(input logic [CMD_ADDR_W-1:0] a);
    if (AUTO_INC == 0) return a;
    if ({1'b0, a} < 8'(N_TOT)) begin
      if ({1'b0, a} == 8'(N_TOT - 1)) return (WRAP != 0) ? ADDR_ZERO : a;
      return a + 1'b1;
    end
    if (a == ADDR_TOP) return (WRAP != 0) ? ADDR_ZERO : a;
    return a + 1'b1;
  endfunction

  assign w_cmd_addr = rx_data[CMD_ADDR_W-1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; cs high always closes the frame.
  always_comb begin
    w_state_nxt = r_state;
    if (cs) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (!r_wait_cs_hi) w_state_nxt = ST_CMD;
        ST_CMD:  if (rx_valid) w_state_nxt = rx_data[CMD_WR_BIT] ? ST_WDATA : ST_RDATA;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Per-state qualifiers; a byte or request arriving with cs high is dropped.
  always_comb begin
    w_busy     = (r_state != ST_IDLE);
    w_cmd_byte = (r_state == ST_CMD)   && rx_valid && !cs;
    w_wr_byte  = (r_state == ST_WDATA) && rx_valid && !cs;
    w_rd_cmd   = w_cmd_byte && !rx_data[CMD_WR_BIT];
    w_rd_next  = (r_state == ST_RDATA) && tx_req && !cs;
    w_load     = w_rd_cmd || w_rd_next;
    w_rd_addr  = (r_state == ST_CMD) ? w_cmd_addr : r_addr;
  end

  // After reset a frame already in flight must not resume: hold off until cs is seen high.
  always_ff @(posedge clk) begin
    if (rst)     r_wait_cs_hi <= 1'b1;
    else if (cs) r_wait_cs_hi <= 1'b0;
  end

  // Address counter: a read command consumes its start address immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr <= ADDR_ZERO;
    end else if (w_cmd_byte) begin
      r_addr <= rx_data[CMD_WR_BIT] ? w_cmd_addr : next_addr(w_cmd_addr);
    end else if (w_wr_byte || w_rd_next) begin
      r_addr <= next_addr(r_addr);
    end
  end

  // Saturating count of data bytes aimed at read-only or unmapped addresses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err_cnt <= 8'h00;
    end else if (w_wr_byte && !w_wr_legal && (r_err_cnt != 8'hFF)) begin
      r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  // Transmit byte: loaded on read entry and each tx_req, zero outside reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_data <= 8'h00;
    end else if (w_load) begin
      r_tx_data <= w_rd_data;
    end else if (w_state_nxt != ST_RDATA) begin
      r_tx_data <= 8'h00;
    end
  end

  drac_regfile #(
    .N_WR (N_WR),
    .N_RD (N_RD)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .i_wr_en    (w_wr_byte),
    .i_wr_addr  (r_addr),
    .i_wr_data  (rx_data),
    .i_rd_addr  (w_rd_addr),
    .i_regr     (regr),
    .o_regwr    (regwr),
    .o_wr_stb   (wr_stb),
    .o_rd_data  (w_rd_data),
    .o_wr_legal (w_wr_legal)
  );

  assign tx_data = r_tx_data;
  assign err_cnt = r_err_cnt;
  assign busy    = w_busy;

endmodule

// File: tb/tb_drac_burst.sv
// Bench for drac_burst: a cycle table, directed multi-cycle sequences and
// randomized frames checked against a frame-level model.
module tb_drac_burst;

  localparam int NW = 42;
  localparam int NR = 6;
  localparam int NT = NW + NR;
  localparam int RW = NW * 8;
  localparam int NV = 28;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cs = 1'b1;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          tx_req = 1'b0;
  logic [NR*8-1:0] regr = 48'hA5_66_77_88_99_AA;

  logic [7:0]    tx_data, tx_data_h;
  logic [RW-1:0] regwr, regwr_h;
  logic [NW-1:0] wr_stb, wr_stb_h;
  logic [7:0]    err_cnt, err_cnt_h;
  logic          busy, busy_h;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  drac_burst #(.N_WR(NW), .N_RD(NR), .AUTO_INC(1), .WRAP(1)) u_dut (
    .clk(clk), .rst(rst), .cs(cs), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_req(tx_req), .tx_data(tx_data), .regwr(regwr), .regr(regr),
    .wr_stb(wr_stb), .err_cnt(err_cnt), .busy(busy)
  );

  drac_burst #(.N_WR(NW), .N_RD(NR), .AUTO_INC(0), .WRAP(1)) u_dut_hold (
    .clk(clk), .rst(rst), .cs(cs), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_req(tx_req), .tx_data(tx_data_h), .regwr(regwr_h), .regr(regr),
    .wr_stb(wr_stb_h), .err_cnt(err_cnt_h), .busy(busy_h)
  );

  typedef struct {
    logic          cs;
    logic          rv;
    logic [7:0]    rd;
    logic          tq;
    logic          busy;
    logic [7:0]    tx;
    logic [7:0]    err;
    logic [NW-1:0] stb;
  } vec_t;

  vec_t tbl [NV];

  logic [7:0] m_regs [NW];
  int         m_err;

  function automatic vec_t mk(input logic c, input logic v, input logic [7:0] d,
                              input logic q, input logic b, input logic [7:0] t,
                              input logic [7:0] e, input int sb);
    vec_t r;
    r.cs = c; r.rv = v; r.rd = d; r.tq = q;
    r.busy = b; r.tx = t; r.err = e;
    r.stb = '0;
    if (sb >= 0) r.stb[sb] = 1'b1;
    return r;
  endfunction

  // Reference address rule, in plain integer arithmetic.
  function automatic int m_adv(input int a);
    if (a < NT) return (a + 1) % NT;
    return (a == 127) ? 0 : a + 1;
  endfunction

  function automatic logic [7:0] m_read(input int a);
    if (a < NW) return m_regs[a];
    if (a < NT) return regr[8*(a-NW) +: 8];
    return 8'h00;
  endfunction

  function automatic logic [RW-1:0] m_flat();
    logic [RW-1:0] f;
    for (int i = 0; i < NW; i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic v, input logic [7:0] d, input logic q);
    cs = c; rx_valid = v; rx_data = d; tx_req = q;
    step();
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RW-1:0] exp_w;
    logic [RW-1:0] exp_h;
    logic [NW-1:0] es;
    logic [7:0]    d;
    logic [7:0]    exp_tx;
    int cnt, a, wr, addr, len, sel;

    // cs, rv, rd, tq | busy, tx, err, stb bit
    tbl[0]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 8'd0, -1);
    tbl[1]  = mk(0, 0, 8'h00, 0, 1, 8'h00, 8'd0, -1);
    tbl[2]  = mk(0, 1, 8'h82, 0, 1, 8'h00, 8'd0, -1);
    tbl[3]  = mk(0, 1, 8'h11, 0, 1, 8'h00, 8'd0,  2);
    tbl[4]  = mk(0, 0, 8'h00, 0, 1, 8'h00, 8'd0, -1);
    tbl[5]  = mk(0, 1, 8'h22, 0, 1, 8'h00, 8'd0,  3);
    tbl[6]  = mk(0, 1, 8'h33, 0, 1, 8'h00, 8'd0,  4);
    tbl[7]  = mk(0, 0, 8'h00, 0, 1, 8'h00, 8'd0, -1);
    tbl[8]  = mk(1, 0, 8'h00, 0, 0, 8'h00, 8'd0, -1);
    tbl[9]  = mk(0, 0, 8'h00, 0, 1, 8'h00, 8'd0, -1);
    tbl[10] = mk(0, 1, 8'h80, 0, 1, 8'h00, 8'd0, -1);
    tbl[11] = mk(0, 1, 8'h5A, 0, 1, 8'h00, 8'd0,  0);
    tbl[12] = mk(0, 1, 8'hC3, 0, 1, 8'h00, 8'd0,  1);
    tbl[13] = mk(1, 0, 8'h00, 0, 0, 8'h00, 8'd0, -1);
    tbl[14] = mk(0, 0, 8'h00, 0, 1, 8'h00, 8'd0, -1);
    tbl[15] = mk(0, 1, 8'h2F, 0, 1, 8'hA5, 8'd0, -1);
    tbl[16] = mk(0, 0, 8'h00, 1, 1, 8'h5A, 8'd0, -1);
    tbl[17] = mk(0, 0, 8'h00, 0, 1, 8'h5A, 8'd0, -1);
    tbl[18] = mk(0, 0, 8'h00, 1, 1, 8'hC3, 8'd0, -1);
    tbl[19] = mk(0, 0, 8'h00, 1, 1, 8'h11, 8'd0, -1);
    tbl[20] = mk(0, 1, 8'h99, 0, 1, 8'h11, 8'd0, -1);
    tbl[21] = mk(1, 0, 8'h00, 0, 0, 8'h00, 8'd0, -1);
    tbl[22] = mk(0, 0, 8'h00, 0, 1, 8'h00, 8'd0, -1);
    tbl[23] = mk(0, 1, 8'hAA, 0, 1, 8'h00, 8'd0, -1);
    tbl[24] = mk(0, 1, 8'h01, 0, 1, 8'h00, 8'd1, -1);
    tbl[25] = mk(0, 1, 8'h02, 0, 1, 8'h00, 8'd2, -1);
    tbl[26] = mk(1, 1, 8'h03, 0, 0, 8'h00, 8'd2, -1);
    tbl[27] = mk(1, 0, 8'h00, 1, 0, 8'h00, 8'd2, -1);

    // Reset state.
    rst = 1'b1;
    step();
    step();
    chk8("reset busy", {7'd0, busy}, 8'd0);
    chk8("reset tx_data", tx_data, 8'h00);
    chk8("reset err_cnt", err_cnt, 8'h00);
    chkw("reset regwr", regwr, '0);
    chkw("reset wr_stb", RW'(wr_stb), '0);
    rst = 1'b0;

    // Write burst, read wrap through regr[5], illegal writes, drop on cs.
    for (int i = 0; i < NV; i++) begin
      cs = tbl[i].cs; rx_valid = tbl[i].rv; rx_data = tbl[i].rd; tx_req = tbl[i].tq;
      step();
      chk8($sformatf("vec%0d busy", i), {7'd0, busy}, {7'd0, tbl[i].busy});
      chk8($sformatf("vec%0d tx_data", i), tx_data, tbl[i].tx);
      chk8($sformatf("vec%0d err_cnt", i), err_cnt, tbl[i].err);
      chkw($sformatf("vec%0d wr_stb", i), RW'(wr_stb), RW'(tbl[i].stb));
    end
    drive(1, 0, 8'h00, 0);
    exp_w = '0;
    exp_w[7:0] = 8'h5A; exp_w[15:8] = 8'hC3;
    exp_w[23:16] = 8'h11; exp_w[31:24] = 8'h22; exp_w[39:32] = 8'h33;
    chkw("table regwr", regwr, exp_w);
    exp_h = '0;
    exp_h[7:0] = 8'hC3; exp_h[23:16] = 8'h33;
    chkw("table regwr hold", regwr_h, exp_h);
    chk8("table err hold", err_cnt_h, 8'd2);

    // Address held: both bytes land on register 5.
    drive(0, 0, 8'h00, 0);
    drive(0, 1, 8'h85, 0);
    cnt = 0;
    drive(0, 1, 8'h01, 0); cnt += int'(wr_stb_h[5]);
    drive(0, 0, 8'h00, 0); cnt += int'(wr_stb_h[5]);
    drive(0, 1, 8'h02, 0); cnt += int'(wr_stb_h[5]);
    drive(0, 0, 8'h00, 0); cnt += int'(wr_stb_h[5]);
    drive(1, 0, 8'h00, 0);
    chk8("hold stb5 pulses", 8'(cnt), 8'd2);
    chk8("hold regwr5", regwr_h[47:40], 8'h02);
    chk8("inc regwr5", regwr[47:40], 8'h01);
    chk8("inc regwr6", regwr[55:48], 8'h02);
    exp_h[47:40] = 8'h02;

    // cs rising together with a legal data byte drops the byte.
    drive(0, 0, 8'h00, 0);
    drive(0, 1, 8'h8A, 0);
    drive(0, 1, 8'h44, 0);
    es = '0; es[10] = 1'b1;
    chkw("abort first stb", RW'(wr_stb), RW'(es));
    drive(1, 1, 8'h77, 0);
    chk8("abort busy", {7'd0, busy}, 8'd0);
    chkw("abort stb", RW'(wr_stb), '0);
    chk8("abort regwr10", regwr[87:80], 8'h44);
    drive(1, 0, 8'h00, 0);
    exp_h[87:80] = 8'h44;

    // Saturation on the held-address instance parked at address 42.
    drive(0, 0, 8'h00, 0);
    drive(0, 1, 8'hAA, 0);
    for (int k = 1; k <= 300; k++) begin
      drive(0, 1, 8'($urandom), 0);
      if (k == 252) chk8("sat err 254", err_cnt_h, 8'd254);
      if (k == 253) chk8("sat err 255", err_cnt_h, 8'd255);
    end
    drive(1, 0, 8'h00, 0);
    chk8("sat err final", err_cnt_h, 8'd255);
    chkw("sat regwr unchanged", regwr_h, exp_h);

    // Reset in the middle of a read frame, then the cs re-arm requirement.
    drive(0, 0, 8'h00, 0);
    drive(0, 1, 8'h2F, 0);
    chk8("pre-rst tx", tx_data, 8'hA5);
    rst = 1'b1;
    drive(0, 0, 8'h00, 0);
    rst = 1'b0;
    chk8("rst tx", tx_data, 8'h00);
    chk8("rst busy", {7'd0, busy}, 8'd0);
    chk8("rst err", err_cnt, 8'd0);
    chkw("rst regwr", regwr, '0);
    chkw("rst regwr hold", regwr_h, '0);
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 8'h00, 0);
      chk8($sformatf("rearm busy %0d", k), {7'd0, busy}, 8'd0);
    end
    drive(1, 0, 8'h00, 0);
    drive(0, 0, 8'h00, 0);
    chk8("rearm open", {7'd0, busy}, 8'd1);
    drive(1, 0, 8'h00, 0);

    // Randomized frames against the model.
    for (int i = 0; i < NW; i++) m_regs[i] = 8'h00;
    m_err = 0;
    for (int f = 0; f < 150; f++) begin
      regr = {16'($urandom), 32'($urandom)};
      drive(1, 0, 8'h00, 0);
      drive(0, 0, 8'h00, 0);
      wr  = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       addr = int'($urandom_range(0, 127));
        1:       addr = int'($urandom_range(38, 47));
        2:       addr = int'($urandom_range(44, 53));
        default: addr = int'($urandom_range(118, 127));
      endcase
      len = int'($urandom_range(1, 6));
      drive(0, 1, 8'((wr << 7) | addr), 0);
      a = addr;
      if (wr == 0) begin
        exp_tx = m_read(a);
        chk8($sformatf("rnd%0d rd entry a=%0d", f, a), tx_data, exp_tx);
        a = m_adv(a);
        for (int k = 0; k < len; k++) begin
          if ($urandom_range(0, 2) == 0) begin
            drive(0, 1, 8'($urandom), 0);
            chk8($sformatf("rnd%0d rd hold", f), tx_data, exp_tx);
          end
          if ($urandom_range(0, 1) == 1) regr = {16'($urandom), 32'($urandom)};
          drive(0, 0, 8'h00, 1);
          exp_tx = m_read(a);
          chk8($sformatf("rnd%0d rd a=%0d", f, a), tx_data, exp_tx);
          a = m_adv(a);
        end
      end else begin
        for (int k = 0; k < len; k++) begin
          d = 8'($urandom);
          drive(0, 1, d, 0);
          es = '0;
          if (a < NW) begin
            es[a] = 1'b1;
            m_regs[a] = d;
          end else if (m_err < 255) begin
            m_err++;
          end
          chkw($sformatf("rnd%0d wr stb a=%0d", f, a), RW'(wr_stb), RW'(es));
          chk8($sformatf("rnd%0d wr err", f), err_cnt, 8'(m_err));
          chkw($sformatf("rnd%0d wr regwr", f), regwr, m_flat());
          a = m_adv(a);
          if ($urandom_range(0, 1) == 1) begin
            drive(0, 0, 8'h00, 0);
            chkw($sformatf("rnd%0d stb low", f), RW'(wr_stb), '0);
          end
        end
      end
      drive(1, 0, 8'h00, 0);
      chk8($sformatf("rnd%0d end busy", f), {7'd0, busy}, 8'd0);
      chk8($sformatf("rnd%0d end tx", f), tx_data, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
